tone_gen: RTL and testbench

//  Parametrised audio tone source. Replaces the fixed 500 Hz square-wave counter that drives the

---
 rtl/tone_gen.sv | 179 +++++++++++++++++
 tb/tb_tone_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_gen.sv
// Phase-accumulator tone source (square/saw/triangle/mute) with amplitude scaling for the Audio PWM.
// Latency: sample tick -> value/sample_stb/wrap/LED = 2 cycles; one sample every SAMPLE_DIV cycles.
// Backpressure: single pending config slot; cfg_ready low until it is applied on a phase wrap or while disabled.
// Optional feature: define TONE_GEN_DUTY_EN to add cfg_duty (programmable square duty).
module tone_gen #(
  parameter int OUT_W       = 11,
  parameter int ACC_W       = 24,
  parameter int SAMPLE_DIV  = 1000,
  parameter int DEFAULT_FTW = 83886
) (
  input  logic             CLK_100M,
  input  logic             RST,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [1:0]       cfg_mode,
  input  logic [OUT_W-1:0] cfg_amp,
`ifdef TONE_GEN_DUTY_EN
  input  logic [OUT_W-1:0] cfg_duty,
`endif
  output logic [OUT_W-1:0] value,
  output logic             sample_stb,
  output logic             wrap,
  output logic             LED
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_MUTE   = 2'd3
  } mode_e;

  // ftw, mode, amp (and duty) travel together so an update is atomic
  typedef struct packed {
    logic [ACC_W-1:0] ftw;
    mode_e            mode;
    logic [OUT_W-1:0] amp;
`ifdef TONE_GEN_DUTY_EN
    logic [OUT_W-1:0] duty;
`endif
  } cfg_t;

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [ACC_W-1:0]   phase;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               carry_q;
  logic               en_q;
  logic               s1_vld;
  cfg_t               act;
  cfg_t               pend;
  cfg_t               cfg_in;
  cfg_t               cfg_rst;
  logic               pend_vld;
  logic               accept;
  logic               apply;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   q;
  logic [OUT_W-1:0]   raw;
  logic [2*OUT_W-1:0] prod;
  logic [OUT_W-1:0]   scaled;

  assign tick   = (div == DIV_W'(SAMPLE_DIV - 1));
  assign sum    = {1'b0, phase} + {1'b0, act.ftw};
  assign carry  = enable & sum[ACC_W];
  assign accept = cfg_valid & ~pend_vld;
  // Swap configs only at a phase wrap so the waveform never jumps mid-cycle;
  // when silent there is nothing to glitch, so apply straight away.
  assign apply  = pend_vld & (~enable | (tick & carry));
  assign cfg_ready = ~pend_vld;

  always_comb begin
    cfg_in      = '0;
    cfg_in.ftw  = cfg_ftw;
    cfg_in.mode = mode_e'(cfg_mode);
    cfg_in.amp  = cfg_amp;
`ifdef TONE_GEN_DUTY_EN
    cfg_in.duty = cfg_duty;
`endif
  end

  always_comb begin
    cfg_rst      = '0;
    cfg_rst.ftw  = ACC_W'(DEFAULT_FTW);
    cfg_rst.mode = MODE_SQUARE;
    cfg_rst.amp  = '1;
`ifdef TONE_GEN_DUTY_EN
    cfg_rst.duty = {1'b1, {(OUT_W-1){1'b0}}};
`endif
  end

  // Free-running sample-rate divider, independent of enable
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Stage 1: advance the phase on each tick and remember carry/enable for the output stage
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      phase   <= '0;
      carry_q <= 1'b0;
      en_q    <= 1'b0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= tick;
      if (tick) begin
        phase   <= enable ? sum[ACC_W-1:0] : '0;
        carry_q <= carry;
        en_q    <= enable;
      end
    end
  end

  // Config capture into the single pending slot, promoted to active on apply
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      act      <= cfg_rst;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else if (accept) begin
      pend     <= cfg_in;
      pend_vld <= 1'b1;
    end else if (apply) begin
      act      <= pend;
      pend_vld <= 1'b0;
    end
  end

  assign p = phase[ACC_W-1 -: OUT_W];
  assign q = phase[ACC_W-2 -: OUT_W];

  // Raw waveform from the current phase
  always_comb begin
    raw = '0;
    case (act.mode)
`ifdef TONE_GEN_DUTY_EN
      MODE_SQUARE: raw = (p < act.duty) ? '1 : '0;
`else
      MODE_SQUARE: raw = phase[ACC_W-1] ? '1 : '0;
`endif
      MODE_SAW:    raw = p;
      MODE_TRI:    raw = phase[ACC_W-1] ? ~q : q;
      default:     raw = '0;
    endcase
  end

  // Truncating scale: all-ones amp is just short of unity
  assign prod   = {{OUT_W{1'b0}}, raw} * {{OUT_W{1'b0}}, act.amp};
  assign scaled = OUT_W'(prod >> OUT_W);

  // Stage 2: register the scaled sample and its strobes
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      value      <= '0;
      sample_stb <= 1'b0;
      wrap       <= 1'b0;
      LED        <= 1'b0;
    end else begin
      sample_stb <= s1_vld;
      wrap       <= s1_vld & carry_q;
      if (s1_vld) begin
        value <= en_q ? scaled : '0;
        LED   <= en_q & phase[ACC_W-1];
      end
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at OUT_W=4, ACC_W=8, SAMPLE_DIV=4, DEFAULT_FTW=8'h20.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario task checks its own expected values inline.
module tb_tone_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_ftw = 8'h00;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_amp = 4'd0;
`ifdef TONE_GEN_DUTY_EN
  logic [3:0] cfg_duty = 4'd8;
`endif
  logic [3:0] value;
  logic       sample_stb;
  logic       wrap;
  logic       led;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tone_gen #(
    .OUT_W(4),
    .ACC_W(8),
    .SAMPLE_DIV(4),
    .DEFAULT_FTW(8'h20)
  ) dut (
    .CLK_100M  (clk),
    .RST       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ftw   (cfg_ftw),
    .cfg_mode  (cfg_mode),
    .cfg_amp   (cfg_amp),
`ifdef TONE_GEN_DUTY_EN
    .cfg_duty  (cfg_duty),
`endif
    .value     (value),
    .sample_stb(sample_stb),
    .wrap      (wrap),
    .LED       (led)
  );

  // Advance falling edges until sample_stb is seen (bounded)
  task automatic wait_stb(output bit got);
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (sample_stb) got = 1'b1;
    end
  endtask

  // Offer a config and hold it until the cycle it is accepted; returns one edge later
  task automatic send_cfg(input logic [7:0] ftw, input logic [1:0] mode,
                          input logic [3:0] amp, input logic [3:0] duty, output bit ok);
    int n;
    cfg_ftw   = ftw;
    cfg_mode  = mode;
    cfg_amp   = amp;
`ifdef TONE_GEN_DUTY_EN
    cfg_duty  = duty;
`else
    if (duty != 4'd0) cfg_amp = amp;
`endif
    cfg_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 60) begin
      if (cfg_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    int first;
    int second;
    rst = 1'b1;
    enable = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (value !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", value); end
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", sample_stb); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", led); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    rst = 1'b0;
    first = -1;
    second = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks++; if (first != 5) begin errors++; $display("FAIL first_stb_cycle: got %0d want 5", first); end
    checks++; if (second != 9) begin errors++; $display("FAIL second_stb_cycle: got %0d want 9", second); end
  endtask

  task automatic test_saw;
    bit got;
    bit ok;
    int exp_v[8] = '{1, 3, 5, 7, 9, 11, 13, 0};
    wait_stb(got);
    checks++; if (!got) begin errors++; $display("FAIL saw_idle_stb: timeout waiting for sample_stb"); end
    checks++; if (value !== 4'd0) begin errors++; $display("FAIL saw_idle_value: got %0d want 0", value); end
    send_cfg(8'h20, 2'd1, 4'd15, 4'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL saw_cfg_accept: timeout on cfg_ready"); end
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL saw_cfg_ready: got %b want 1", cfg_ready); end
    wait_stb(got);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_stb(got);
      checks++; if (!got) begin errors++; $display("FAIL saw_stb[%0d]: timeout", k); end
      checks++; if (value !== 4'(exp_v[k])) begin errors++; $display("FAIL saw_value[%0d]: got %0d want %0d", k, value, exp_v[k]); end
      checks++; if (wrap !== (k == 7)) begin errors++; $display("FAIL saw_wrap[%0d]: got %b want %b", k, wrap, k == 7); end
    end
  endtask

  task automatic test_cfg_change;
    bit got;
    bit ok;
    int exp_v[8] = '{1, 3, 5, 7, 9, 11, 13, 0};
    int exp_f[4] = '{3, 7, 11, 0};
    send_cfg(8'h40, 2'd1, 4'd15, 4'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chg_accept: timeout on cfg_ready"); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL chg_ready_low: got %b want 0", cfg_ready); end
    for (int k = 0; k < 8; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'(exp_v[k])) begin errors++; $display("FAIL chg_old_value[%0d]: got %0d want %0d", k, value, exp_v[k]); end
      checks++; if (cfg_ready !== (k == 7)) begin errors++; $display("FAIL chg_ready[%0d]: got %b want %b", k, cfg_ready, k == 7); end
      checks++; if (wrap !== (k == 7)) begin errors++; $display("FAIL chg_wrap[%0d]: got %b want %b", k, wrap, k == 7); end
    end
    for (int k = 0; k < 4; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'(exp_f[k])) begin errors++; $display("FAIL chg_new_value[%0d]: got %0d want %0d", k, value, exp_f[k]); end
      checks++; if (wrap !== (k == 3)) begin errors++; $display("FAIL chg_new_wrap[%0d]: got %b want %b", k, wrap, k == 3); end
    end
  endtask

  task automatic test_square;
    bit got;
    bit ok;
    logic [7:0] ph;
    send_cfg(8'h20, 2'd0, 4'd8, 4'd8, ok);
    for (int k = 1; k <= 4; k++) wait_stb(got);
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL sq_apply_wrap: got %b want 1", wrap); end
    for (int k = 1; k <= 8; k++) begin
      ph = 8'(k * 32);
      wait_stb(got);
      checks++; if (value !== (ph[7] ? 4'd7 : 4'd0)) begin errors++; $display("FAIL sq_value[%0d]: got %0d want %0d", k, value, ph[7] ? 7 : 0); end
      checks++; if (led !== ph[7]) begin errors++; $display("FAIL sq_led[%0d]: got %b want %b", k, led, ph[7]); end
    end
  endtask

  task automatic test_enable_drop;
    bit got;
    bit ok;
    int exp_v[3] = '{1, 3, 5};
    send_cfg(8'h20, 2'd1, 4'd15, 4'd8, ok);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL en_pending: got %b want 0", cfg_ready); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en_apply_ready: got %b want 1", cfg_ready); end
    for (int k = 0; k < 2; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'd0) begin errors++; $display("FAIL en_off_value[%0d]: got %0d want 0", k, value); end
      checks++; if (led !== 1'b0) begin errors++; $display("FAIL en_off_led[%0d]: got %b want 0", k, led); end
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'(exp_v[k])) begin errors++; $display("FAIL en_restart[%0d]: got %0d want %0d", k, value, exp_v[k]); end
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    bit ok;
    send_cfg(8'h40, 2'd1, 4'd15, 4'd8, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (sample_stb !== 1'b0) begin errors++; $display("FAIL rmid_stb_dropped: got %b want 0", sample_stb); end
    checks++; if (value !== 4'd0) begin errors++; $display("FAIL rmid_value: got %0d want 0", value); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rmid_pending_cleared: got %b want 1", cfg_ready); end
    for (int k = 1; k <= 4; k++) begin
      wait_stb(got);
      checks++; if (value !== ((k == 4) ? 4'd14 : 4'd0)) begin errors++; $display("FAIL rmid_default[%0d]: got %0d want %0d", k, value, (k == 4) ? 14 : 0); end
    end
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL rmid_led: got %b want 1", led); end
  endtask

  task automatic test_triangle;
    bit got;
    bit ok;
    bit seen;
    int exp_v[7] = '{3, 7, 11, 14, 10, 6, 2};
    send_cfg(8'h20, 2'd2, 4'd15, 4'd8, ok);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      wait_stb(got);
      if (wrap) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL tri_wrap: no wrap seen"); end
    checks++; if (value !== 4'd0) begin errors++; $display("FAIL tri_wrap_value: got %0d want 0", value); end
    for (int k = 0; k < 7; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'(exp_v[k])) begin errors++; $display("FAIL tri_value[%0d]: got %0d want %0d", k, value, exp_v[k]); end
    end
  endtask

  task automatic test_ftw_zero;
    bit got;
    bit ok;
    bit seen;
    send_cfg(8'h00, 2'd1, 4'd15, 4'd8, ok);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      wait_stb(got);
      if (wrap) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL fz_apply_wrap: no wrap seen"); end
    for (int k = 0; k < 4; k++) begin
      wait_stb(got);
      checks++; if (value !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL fz_frozen[%0d]: value %0d wrap %b want 0/0", k, value, wrap); end
    end
    send_cfg(8'h20, 2'd1, 4'd15, 4'd8, ok);
    for (int k = 0; k < 4; k++) wait_stb(got);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL fz_stuck_pending: got %b want 0", cfg_ready); end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL fz_disable_apply: got %b want 1", cfg_ready); end
  endtask

`ifdef TONE_GEN_DUTY_EN
  task automatic test_duty;
    bit got;
    bit ok;
    int hi;
    logic [7:0] ph;
    send_cfg(8'h20, 2'd0, 4'd15, 4'd4, ok);
    @(negedge clk);
    wait_stb(got);
    enable = 1'b1;
    hi = 0;
    for (int k = 1; k <= 8; k++) begin
      ph = 8'(k * 32);
      wait_stb(got);
      if (value == 4'd14) hi++;
      checks++; if (value !== ((ph[7:4] < 4'd4) ? 4'd14 : 4'd0)) begin errors++; $display("FAIL duty_value[%0d]: got %0d want %0d", k, value, (ph[7:4] < 4'd4) ? 14 : 0); end
    end
    checks++; if (hi != 2) begin errors++; $display("FAIL duty_count: got %0d want 2", hi); end
  endtask
`endif

  initial begin
    test_reset();
    test_saw();
    test_cfg_change();
    test_square();
    test_enable_drop();
    test_reset_mid();
    test_triangle();
    test_ftw_zero();
`ifdef TONE_GEN_DUTY_EN
    test_duty();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
